// File: rtl/rca_word_sequencer.sv
// Wide adder built from one 4-bit ripple-carry slice, stepped LSB-first over WIDTH/4 cycles.
// Optional subtract mode is enabled by defining RCA_SEQ_SUB_EN.
module rca_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("rca_word_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

`ifdef RCA_SEQ_SUB_EN
  // Two's-complement subtract: invert B and inject a carry of one.
  assign b_cap = op_sub ? ~b_in : b_in;
  assign c_cap = op_sub ? 1'b1 : c_in;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_cap = b_in;
  assign c_cap = c_in;
`endif

  logic [3:0] sl_a, sl_b, sl_s;
  logic [4:0] sl_c;

  assign sl_a    = a_sh_q[3:0];
  assign sl_b    = b_sh_q[3:0];
  assign sl_c[0] = carry_q;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sl_s[i]   = sl_a[i] ^ sl_b[i] ^ sl_c[i];
    assign sl_c[i+1] = (sl_a[i] & sl_b[i]) | (sl_c[i] & (sl_a[i] ^ sl_b[i]));
  end

  // New slice sum enters at the top; earlier slices drift down toward bit 0.
  logic [WIDTH-1:0] res_shift;
  assign res_shift = WIDTH'({sl_s, res_q} >> 4);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_cap;
          carry_d = c_cap;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_shift;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = sl_c[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSLICE - 1)) begin
          sum_d   = res_shift;
          cout_d  = sl_c[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed bench for rca_word_sequencer at WIDTH=16: vector table plus multi-cycle corner cases.
module tb_rca_word_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  rca_word_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    string        name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    a_in     = a;
    b_in     = b;
    c_in     = ci;
    op_sub   = sb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    accept(v.a, v.b, v.cin, v.sub);
    chk({v.name, "_busy"}, {31'd0, busy}, 32'd1);
    chk({v.name, "_not_ready"}, {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk({v.name, "_latency"}, lat, 32'd4);
    chk({v.name, "_sum"}, {16'd0, sum_out}, {16'd0, v.s});
    chk({v.name, "_carry"}, {31'd0, carry_out}, {31'd0, v.co});
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int idx;
    int got;
    int last_acc;
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    logic         pc[3];
    logic [W-1:0] ps[3];
    logic         pco[3];

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "add_1234_4321"};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple_all"};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "max_cin"};
    vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "add_0f0f_00f1"};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "msb_carry"};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, "cin_only"};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, "add_7fff_1"};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, "add_abcd_1111"};
`ifdef RCA_SEQ_SUB_EN
    vecs[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_5_7"};
    vecs[9] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub_7_5"};
`else
    vecs[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, "sub_ignored_a"};
    vecs[9] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h000D, 1'b0, "sub_ignored_b"};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {16'd0, sum_out}, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: result must hold and extra operands must be dropped.
    out_ready = 1'b0;
    accept(16'h1111, 16'h2222, 1'b0, 1'b0);
    a_in     = 16'hFFFF;
    b_in     = 16'hFFFF;
    in_valid = 1'b1;
    wait_valid(lat);
    chk("bp_latency", lat, 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_sum_hold", {16'd0, sum_out}, 32'h3333);
      chk("bp_carry_hold", {31'd0, carry_out}, 32'd0);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_sum_retained", {16'd0, sum_out}, 32'h3333);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp_no_second_result", seen, 32'd0);

    // Reset two slices into a transaction.
    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum_out}, 32'd0);
    chk("midrst_carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    run_vec(vecs[3]);

    // Back-to-back with in_valid held high.
    pa[0] = 16'h0001; pb[0] = 16'h0002; pc[0] = 1'b0; ps[0] = 16'h0003; pco[0] = 1'b0;
    pa[1] = 16'h1234; pb[1] = 16'h4321; pc[1] = 1'b1; ps[1] = 16'h5556; pco[1] = 1'b0;
    pa[2] = 16'hFFFF; pb[2] = 16'h0001; pc[2] = 1'b0; ps[2] = 16'h0000; pco[2] = 1'b1;
    out_ready = 1'b1;
    op_sub    = 1'b0;
    idx       = 0;
    got       = 0;
    last_acc  = 0;
    a_in      = pa[0];
    b_in      = pb[0];
    c_in      = pc[0];
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      if (out_valid) begin
        chk("b2b_sum", {16'd0, sum_out}, {16'd0, ps[got]});
        chk("b2b_carry", {31'd0, carry_out}, {31'd0, pco[got]});
        got++;
      end
      if (in_valid && in_ready) begin
        if (idx > 0) chk("b2b_gap_min", {31'd0, (cyc - last_acc) >= 5}, 32'd1);
        last_acc = cyc;
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
      if (idx < 3) begin
        a_in = pa[idx];
        b_in = pb[idx];
        c_in = pc[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", idx, 32'd3);
    chk("b2b_results", got, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
